rte_clock_bank: RTL and testbench
=================================

Name: rte_clock_bank

Overview:
- Parametrised successor to the fixed 8-clock constraint unit of the RTE core.
- Holds NUM_CLOCKS timed clocks of uniform width CLK_WIDTH. Each clock has its own prescaler and advances on global ticks (the controller's flush event).
- Supports grouped resets via join chains.
- Evaluates one clock constraint (clock vs immediate, 4 compare modes) per request, with a registered result and a valid strobe consumed by the inputs module.

Parameters:
- NUM_CLOCKS, 8, number of clocks (2..32).
- CLK_WIDTH, 12, counter width per clock (4..32).
- DIV_WIDTH, 10, prescaler limit width.
- ADDR_W, $clog2(NUM_CLOCKS), clock select width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  global time step (flush event).
- en_clk_reset  in  1  apply reset mask this cycle.
- clk_reset  in  NUM_CLOCKS  per-clock reset request mask.
- cfg_div_limits  in  NUM_CLOCKS*DIV_WIDTH  prescaler limit per clock; clock i at bits [i*DIV_WIDTH +: DIV_WIDTH].
- cfg_clk_joins  in  NUM_CLOCKS-1  join[i]=1 chains clock i's reset to clock i+1.
- req  in  1  constraint evaluation request.
- req_addr  in  ADDR_W  clock to compare.
- req_op  in  2  00 lt, 01 eq, 10 ge, 11 gt.
- req_imm  in  CLK_WIDTH  comparison immediate.
- out_valid  out  1  result strobe.
- out_val  out  1  constraint result.
- db_clocks  out  NUM_CLOCKS*CLK_WIDTH  counter values, flattened.

Behaviour:
- Reset (synchronous): all counters, prescalers, out_val and out_valid go to 0.
- Effective reset mask: er[0] = en_clk_reset & clk_reset[0]; er[i] = en_clk_reset & (clk_reset[i] | (cfg_clk_joins[i-1] & er[i-1])). The chain ripples combinationally, lowest index upward.
- On tick with er[i]=0:
  - If prescaler[i] == limit[i], prescaler[i] becomes 0 and counter[i] increments.
  - Otherwise prescaler[i] increments.
  - limit 0 means the counter advances every tick.
- Counter saturation: counter[i] saturates at all-ones. The prescaler keeps cycling while saturated.
- er[i]=1 zeroes counter[i] and prescaler[i]. It takes priority over a tick in the same cycle.
- Limit changed mid-count: compare against the new limit. If the prescaler is already above the new limit, it continues up and wraps at the DIV_WIDTH maximum to 0. There is no increment on that wrap.
- Evaluation:
  - req in cycle N latches a result that appears in cycle N+1 with out_valid=1 for exactly one cycle.
  - The comparison is unsigned. It uses the counter value registered before any cycle-N update; a same-cycle tick or reset is not visible.
  - req_addr >= NUM_CLOCKS gives out_val=0 and out_valid=1.
- Back-to-back reqs give back-to-back results; no stall.
- out_val holds its last value when out_valid=0.
- Reset asserted mid-operation cancels a pending result: out_valid=0 the next cycle.

Optional Feature:
- Macro: RTE_CLOCK_BANK_WRAP_EN.
- Defined:
  - Counters wrap from all-ones to 0 instead of saturating.
  - Adds port ovf out NUM_CLOCKS, a sticky per-clock overflow flag. ovf[i] is set on wrap and cleared by er[i] or reset.
  - A request against a clock whose ovf bit is set returns out_val=1 for ge/gt and 0 for lt/eq.
- Undefined: saturating counters; no ovf port.

Decomposition:
- Shared package rte_pkg:
  - Compare-op encodings CMP_LT/CMP_EQ/CMP_GE/CMP_GT.
  - Default widths CLK_WIDTH_DEF and DIV_WIDTH_DEF.
  - Function for flattened slice indexing.
- Sub-module rte_prescaled_counter: one prescaler plus counter, with its saturation/wrap logic. Instantiated NUM_CLOCKS times by generate. The join chain and compare stay in the top.

Test Plan:
1. Reset, set limit[0]=2, pulse tick 9 times -> counter[0]=3; limit[1]=0 with 9 ticks -> counter[1]=9.
2. CLK_WIDTH=4, limit 0, 20 ticks -> counter holds at 15. With RTE_CLOCK_BANK_WRAP_EN -> counter=4, ovf[0]=1.
3. joins=0b011, clk_reset=0b001 with en_clk_reset -> clocks 0,1,2 zeroed, clock 3 unchanged. Same mask with tick in the same cycle -> reset wins.
4. counter[2]=5: req op=lt imm=6 -> next cycle out_valid=1, out_val=1. Then op=eq imm=5 -> 1, op=gt imm=5 -> 0, op=ge imm=5 -> 1, back-to-back with no gaps.
5. NUM_CLOCKS=6, req_addr=7 -> out_valid=1, out_val=0.
6. req issued and reset asserted the next cycle -> out_valid=0, all counters 0.

Source files
------------

// File: rtl/rte_pkg.sv
// rte_pkg: shared definitions for the RTE clock bank.
//   cmp_op_e       - constraint compare encodings (lt, eq, ge, gt)
//   CLK_WIDTH_DEF  - default counter width
//   DIV_WIDTH_DEF  - default prescaler limit width
//   slice_lo()     - low bit index of element idx in a flattened bus
package rte_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'b00,
    CMP_EQ = 2'b01,
    CMP_GE = 2'b10,
    CMP_GT = 2'b11
  } cmp_op_e;

  localparam int CLK_WIDTH_DEF = 12;
  localparam int DIV_WIDTH_DEF = 10;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rte_prescaled_counter.sv
// rte_prescaled_counter: one prescaler plus one timed clock counter.
// Optional feature macro: RTE_CLOCK_BANK_WRAP_EN (wrap + sticky overflow).
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   tick        - global time step
//   clr         - effective per-clock reset (beats tick)
//   limit       - prescaler limit; counter advances when prescaler == limit
//   count       - current counter value
//   ovf         - sticky overflow flag (only with RTE_CLOCK_BANK_WRAP_EN)
module rte_prescaled_counter #(
  parameter int CLK_WIDTH = 12,
  parameter int DIV_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] limit,
`ifdef RTE_CLOCK_BANK_WRAP_EN
  output logic                 ovf,
`endif
  output logic [CLK_WIDTH-1:0] count
);

  logic [DIV_WIDTH-1:0] presc;

  // A prescaler already past a freshly lowered limit keeps counting and
  // wraps naturally at its width maximum, without advancing the counter.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      presc <= '0;
      count <= '0;
`ifdef RTE_CLOCK_BANK_WRAP_EN
      ovf   <= 1'b0;
`endif
    end else if (tick) begin
      if (presc == limit) begin
        presc <= '0;
`ifdef RTE_CLOCK_BANK_WRAP_EN
        count <= count + 1'b1;
        if (&count) ovf <= 1'b1;
`else
        if (!(&count)) count <= count + 1'b1;
`endif
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rte_clock_bank.sv
// rte_clock_bank: bank of NUM_CLOCKS prescaled timed clocks with chained
// grouped resets and a single registered clock-vs-immediate constraint check.
// Optional feature macro: RTE_CLOCK_BANK_WRAP_EN (wrapping counters, ovf port).
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   tick            - global time step
//   en_clk_reset    - apply clk_reset mask this cycle
//   clk_reset       - per-clock reset request
//   cfg_div_limits  - flattened per-clock prescaler limits
//   cfg_clk_joins   - join[i] propagates clock i's reset to clock i+1
//   req/req_addr/req_op/req_imm - constraint evaluation request
//   out_valid/out_val - registered result, valid for one cycle per request
//   db_clocks       - flattened counter values
//   ovf             - sticky per-clock overflow (RTE_CLOCK_BANK_WRAP_EN only)
module rte_clock_bank
  import rte_pkg::*;
#(
  parameter  int NUM_CLOCKS = 8,
  parameter  int CLK_WIDTH  = CLK_WIDTH_DEF,
  parameter  int DIV_WIDTH  = DIV_WIDTH_DEF,
  localparam int ADDR_W     = $clog2(NUM_CLOCKS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            en_clk_reset,
  input  logic [NUM_CLOCKS-1:0]           clk_reset,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] cfg_div_limits,
  input  logic [NUM_CLOCKS-2:0]           cfg_clk_joins,
  input  logic                            req,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [1:0]                      req_op,
  input  logic [CLK_WIDTH-1:0]            req_imm,
  output logic                            out_valid,
  output logic                            out_val,
`ifdef RTE_CLOCK_BANK_WRAP_EN
  output logic [NUM_CLOCKS-1:0]           ovf,
`endif
  output logic [NUM_CLOCKS*CLK_WIDTH-1:0] db_clocks
);

  logic [NUM_CLOCKS-1:0] er;
  logic [CLK_WIDTH-1:0]  counts [NUM_CLOCKS];

  // Join chain ripples upward; a scalar carry keeps the loop acyclic.
  always_comb begin
    logic carry;
    er    = '0;
    carry = en_clk_reset & clk_reset[0];
    er[0] = carry;
    for (int i = 1; i < NUM_CLOCKS; i++) begin
      carry = en_clk_reset & (clk_reset[i] | (cfg_clk_joins[i-1] & carry));
      er[i] = carry;
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_clk
    rte_prescaled_counter #(
      .CLK_WIDTH (CLK_WIDTH),
      .DIV_WIDTH (DIV_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .clr   (er[g]),
      .limit (cfg_div_limits[slice_lo(g, DIV_WIDTH) +: DIV_WIDTH]),
`ifdef RTE_CLOCK_BANK_WRAP_EN
      .ovf   (ovf[g]),
`endif
      .count (counts[g])
    );
    assign db_clocks[slice_lo(g, CLK_WIDTH) +: CLK_WIDTH] = counts[g];
  end

  logic                 hit;
  logic                 sel_ovf;
  logic [CLK_WIDTH-1:0] sel_cnt;
  logic                 cmp_res;

  // Out-of-range addresses never hit, so they evaluate to 0.
  always_comb begin
    hit     = 1'b0;
    sel_ovf = 1'b0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (32'(req_addr) == i) begin
        hit     = 1'b1;
        sel_cnt = counts[i];
`ifdef RTE_CLOCK_BANK_WRAP_EN
        sel_ovf = ovf[i];
`endif
      end
    end
  end

  always_comb begin
    cmp_res = 1'b0;
    case (cmp_op_e'(req_op))
      CMP_LT: cmp_res = sel_cnt <  req_imm;
      CMP_EQ: cmp_res = sel_cnt == req_imm;
      CMP_GE: cmp_res = sel_cnt >= req_imm;
      CMP_GT: cmp_res = sel_cnt >  req_imm;
    endcase
    // An overflowed clock is beyond any immediate: true for ge/gt only.
    if (sel_ovf) cmp_res = req_op[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_val   <= 1'b0;
    end else begin
      out_valid <= req;
      if (req) out_val <= hit & cmp_res;
    end
  end

endmodule

// File: tb/tb_rte_clock_bank.sv
module tb_rte_clock_bank;

  localparam int NC = 6;
  localparam int CW = 4;
  localparam int DW = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DMOD = 1 << DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, tick, en_clk_reset, req;
  logic [NC-1:0]      clk_reset;
  logic [NC*DW-1:0]   cfg_div_limits;
  logic [NC-2:0]      cfg_clk_joins;
  logic [2:0]         req_addr;
  logic [1:0]         req_op;
  logic [CW-1:0]      req_imm;
  logic               out_valid, out_val;
  logic [NC*CW-1:0]   db_clocks;
`ifdef RTE_CLOCK_BANK_WRAP_EN
  logic [NC-1:0]      ovf;
`endif

  rte_clock_bank #(.NUM_CLOCKS(NC), .CLK_WIDTH(CW), .DIV_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .en_clk_reset   (en_clk_reset),
    .clk_reset      (clk_reset),
    .cfg_div_limits (cfg_div_limits),
    .cfg_clk_joins  (cfg_clk_joins),
    .req            (req),
    .req_addr       (req_addr),
    .req_op         (req_op),
    .req_imm        (req_imm),
    .out_valid      (out_valid),
    .out_val        (out_val),
`ifdef RTE_CLOCK_BANK_WRAP_EN
    .ovf            (ovf),
`endif
    .db_clocks      (db_clocks)
  );

  int lim [NC];
  int m_cnt [NC];
  int m_psc [NC];
  bit m_ovf [NC];
  bit m_valid, m_val;
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_cmp();
    int a, c, imm;
    a = int'(req_addr);
    if (a >= NC) return 1'b0;
`ifdef RTE_CLOCK_BANK_WRAP_EN
    if (m_ovf[a]) return req_op[1];
`endif
    c   = m_cnt[a];
    imm = int'(req_imm);
    case (req_op)
      2'd0:    return c < imm;
      2'd1:    return c == imm;
      2'd2:    return c >= imm;
      default: return c > imm;
    endcase
  endfunction

  function automatic int cnt_of(input int i);
    logic [NC*CW-1:0] v;
    v = db_clocks;
    return int'(v[i*CW +: CW]);
  endfunction

  task automatic idle();
    tick = 0; en_clk_reset = 0; clk_reset = '0; req = 0;
  endtask

  // One clock cycle: advance the reference model with the driven inputs,
  // clock the DUT, then compare every observable.
  task automatic cycle();
    bit res, carry, er;
    for (int i = 0; i < NC; i++) cfg_div_limits[i*DW +: DW] = DW'(lim[i]);
    res = model_cmp();
    if (reset) begin
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_psc[i] = 0; m_ovf[i] = 0; end
      m_valid = 0; m_val = 0;
    end else begin
      m_valid = req;
      if (req) m_val = res;
      carry = 0;
      for (int i = 0; i < NC; i++) begin
        if (i == 0) er = en_clk_reset && clk_reset[0];
        else        er = en_clk_reset && (clk_reset[i] || (cfg_clk_joins[i-1] && carry));
        carry = er;
        if (er) begin
          m_cnt[i] = 0; m_psc[i] = 0; m_ovf[i] = 0;
        end else if (tick) begin
          if (m_psc[i] == lim[i]) begin
            m_psc[i] = 0;
`ifdef RTE_CLOCK_BANK_WRAP_EN
            if (m_cnt[i] == CMAX) m_ovf[i] = 1;
            m_cnt[i] = (m_cnt[i] + 1) % (CMAX + 1);
`else
            if (m_cnt[i] < CMAX) m_cnt[i]++;
`endif
          end else begin
            m_psc[i] = (m_psc[i] + 1) % DMOD;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_val", 32'(out_val), 32'(m_val));
    for (int i = 0; i < NC; i++) begin
      check($sformatf("cnt%0d", i), cnt_of(i), m_cnt[i]);
`ifdef RTE_CLOCK_BANK_WRAP_EN
      check($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
`endif
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      idle(); tick = 1; cycle();
    end
    idle();
  endtask

  task automatic ask(input int addr, input int op, input int imm);
    req = 1; req_addr = 3'(addr); req_op = 2'(op); req_imm = CW'(imm);
    cycle();
  endtask

  initial begin
    idle();
    cfg_clk_joins = '0; req_addr = '0; req_op = '0; req_imm = '0;
    lim = '{2, 0, 4, 5, 1, 3};
    reset = 1;
    cycle(); cycle();
    reset = 0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_clocks", 32'(db_clocks), 32'd0);

    // Prescaled counting.
    ticks(9);
    check("p1_cnt0", cnt_of(0), 3);
    check("p1_cnt1", cnt_of(1), 9);

    // Saturation (or wrap with the optional feature) on a 4-bit counter.
    ticks(11);
`ifdef RTE_CLOCK_BANK_WRAP_EN
    check("p2_cnt1", cnt_of(1), 4);
    check("p2_ovf1", 32'(ovf[1]), 32'd1);
`else
    check("p2_cnt1", cnt_of(1), 15);
`endif
    check("p2_cnt3", cnt_of(3), 3);

    // Join chain: clock 0 request ripples to 1 and 2, not to 3.
    cfg_clk_joins = 5'b00011;
    en_clk_reset = 1; clk_reset = 6'b000001;
    cycle();
    check("p3_cnt0", cnt_of(0), 0);
    check("p3_cnt1", cnt_of(1), 0);
    check("p3_cnt2", cnt_of(2), 0);
    check("p3_cnt3", cnt_of(3), 3);
    idle();
    ticks(3);
    en_clk_reset = 1; clk_reset = 6'b000001; tick = 1;
    cycle();
    check("p3_tick_cnt0", cnt_of(0), 0);
    check("p3_tick_cnt1", cnt_of(1), 0);
    idle();

    // Back-to-back compares against counter[2] = 5.
    lim[2] = 0;
    ticks(5);
    check("p4_cnt2", cnt_of(2), 5);
    ask(2, 0, 6); check("p4_lt_v", 32'(out_valid), 32'd1); check("p4_lt", 32'(out_val), 32'd1);
    ask(2, 1, 5); check("p4_eq_v", 32'(out_valid), 32'd1); check("p4_eq", 32'(out_val), 32'd1);
    ask(2, 3, 5); check("p4_gt_v", 32'(out_valid), 32'd1); check("p4_gt", 32'(out_val), 32'd0);
    ask(2, 2, 5); check("p4_ge_v", 32'(out_valid), 32'd1); check("p4_ge", 32'(out_val), 32'd1);
    idle(); cycle();
    check("p4_idle_v", 32'(out_valid), 32'd0);
    check("p4_hold", 32'(out_val), 32'd1);

    // Out-of-range clock select.
    ask(7, 2, 0); check("p5_a7_v", 32'(out_valid), 32'd1); check("p5_a7", 32'(out_val), 32'd0);
    ask(6, 0, 15); check("p5_a6", 32'(out_val), 32'd0);
    idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      tick          = ($urandom_range(0, 1) == 1);
      en_clk_reset  = ($urandom_range(0, 7) == 0);
      clk_reset     = NC'($urandom);
      cfg_clk_joins = 5'($urandom);
      req           = ($urandom_range(0, 1) == 1);
      req_addr      = 3'($urandom_range(0, 7));
      req_op        = 2'($urandom);
      req_imm       = CW'($urandom);
      reset         = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) lim[$urandom_range(0, NC-1)] = $urandom_range(0, DMOD-1);
      cycle();
    end
    reset = 0;
    idle();

    // Reset right after a request cancels its result.
    ticks(4);
    ask(1, 2, 0);
    idle(); reset = 1;
    cycle();
    check("p6_valid", 32'(out_valid), 32'd0);
    check("p6_clocks", 32'(db_clocks), 32'd0);
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
